// File: rtl/div_arb_if.sv
// Purpose : bundles the request, divider and response signals of div_arb.
// Latency : none, wiring only.
// Backpressure: req_vld/req_rdy and rsp_vld/rsp_rdy handshakes; the divider side has none.
//
// Signal summary:
//   req_vld/req_rdy        per-requester valid and one-hot accept
//   req_dividend/divisor   packed operands, requester i at [i*DW +: DW]
//   div_in_vld/dividend/divisor  drive to the shared sequential divider
//   div_out_vld/quotient/remainder  result strobe from the divider
//   rsp_vld/rsp_rdy        response handshake
//   rsp_id/quotient/remainder/dbz/err  response payload
// Modports: slave = the arbiter's view, master = the environment's view.
interface div_arb_if #(
  parameter int DW   = 8,
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_vld;
  logic [NREQ-1:0]    req_rdy;
  logic [NREQ*DW-1:0] req_dividend;
  logic [NREQ*DW-1:0] req_divisor;

  logic               div_in_vld;
  logic [DW-1:0]      div_dividend;
  logic [DW-1:0]      div_divisor;
  logic               div_out_vld;
  logic [DW-1:0]      div_quotient;
  logic [DW-1:0]      div_remainder;

  logic               rsp_vld;
  logic               rsp_rdy;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_quotient;
  logic [DW-1:0]      rsp_remainder;
  logic               rsp_dbz;
  logic               rsp_err;

  modport slave (
    input  req_vld, req_dividend, req_divisor,
    input  div_out_vld, div_quotient, div_remainder,
    input  rsp_rdy,
    output req_rdy,
    output div_in_vld, div_dividend, div_divisor,
    output rsp_vld, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err
  );

  modport master (
    output req_vld, req_dividend, req_divisor,
    output div_out_vld, div_quotient, div_remainder,
    output rsp_rdy,
    input  req_rdy,
    input  div_in_vld, div_dividend, div_divisor,
    input  rsp_vld, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err
  );
endinterface

// File: rtl/div_arb.sv
// Purpose : round-robin scheduler sharing one sequential radix-2 divider among NREQ requesters.
// Latency : accept at T -> div_in_vld T+1..T+DW+1, rsp_vld at T+DW+3; divide-by-zero rsp_vld at T+1.
// Backpressure: one job in flight; req_rdy only in IDLE, response held stable until rsp_rdy.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; abandons any job without a response
//   bus   div_arb_if.slave: requester, divider and response signals
module div_arb #(
  parameter int DW   = 8,
  parameter int NREQ = 4,
  parameter int WDOG = 3
) (
  input  logic     clk,
  input  logic     rst,
  div_arb_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int RCW = $clog2(DW + 1);
  localparam int WCW = (WDOG > 1) ? $clog2(WDOG) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]     r_state;
  logic [IDW-1:0] r_last_grant;
  logic [RCW-1:0] r_run_cnt;
  logic [WCW-1:0] r_wait_cnt;
  logic [DW-1:0]  r_op_dividend;
  logic [DW-1:0]  r_op_divisor;
  logic [IDW-1:0] r_op_id;
  logic           r_div_in_vld;
  logic           r_rsp_vld;
  logic [DW-1:0]  r_rsp_quotient;
  logic [DW-1:0]  r_rsp_remainder;
  logic           r_rsp_dbz;
  logic           r_rsp_err;

  logic           w_grant_vld;
  logic [IDW-1:0] w_grant_idx;
  logic [NREQ-1:0] w_req_rdy;
  logic [DW-1:0]  w_sel_dividend;
  logic [DW-1:0]  w_sel_divisor;

  // Round-robin pick: the lowest pending index above the last grant wins;
  // if none, wrap around to the lowest pending index at or below it.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_grant_vld && bus.req_vld[i] && (IDW'(i) > r_last_grant)) begin
        w_grant_vld = 1'b1;
        w_grant_idx = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_grant_vld && bus.req_vld[i] && (IDW'(i) <= r_last_grant)) begin
        w_grant_vld = 1'b1;
        w_grant_idx = IDW'(i);
      end
    end
    // Only IDLE can take a new job.
    if (r_state != S_IDLE) begin
      w_grant_vld = 1'b0;
    end
  end

  always_comb begin
    w_req_rdy      = '0;
    w_sel_dividend = '0;
    w_sel_divisor  = '0;
    if (w_grant_vld) begin
      w_req_rdy[w_grant_idx] = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == w_grant_idx) begin
        w_sel_dividend = bus.req_dividend[i*DW +: DW];
        w_sel_divisor  = bus.req_divisor[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      // Pointing at the last requester makes requester 0 first in line.
      r_last_grant    <= IDW'(NREQ - 1);
      r_run_cnt       <= '0;
      r_wait_cnt      <= '0;
      r_op_dividend   <= '0;
      r_op_divisor    <= '0;
      r_op_id         <= '0;
      r_div_in_vld    <= 1'b0;
      r_rsp_vld       <= 1'b0;
      r_rsp_quotient  <= '0;
      r_rsp_remainder <= '0;
      r_rsp_dbz       <= 1'b0;
      r_rsp_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_op_dividend <= w_sel_dividend;
            r_op_divisor  <= w_sel_divisor;
            r_op_id       <= w_grant_idx;
            r_last_grant  <= w_grant_idx;
            if (w_sel_divisor == '0) begin
              // Divide-by-zero never touches the divider.
              r_state         <= S_RESP;
              r_rsp_vld       <= 1'b1;
              r_rsp_quotient  <= '1;
              r_rsp_remainder <= w_sel_dividend;
              r_rsp_dbz       <= 1'b1;
              r_rsp_err       <= 1'b0;
            end else begin
              r_state      <= S_RUN;
              r_run_cnt    <= '0;
              r_div_in_vld <= 1'b1;
            end
          end
        end

        S_RUN: begin
          // run_cnt walks 0..DW, giving DW+1 enable cycles.
          if (r_run_cnt == RCW'(DW)) begin
            r_state      <= S_WAIT;
            r_div_in_vld <= 1'b0;
            r_wait_cnt   <= '0;
          end else begin
            r_run_cnt <= r_run_cnt + 1'b1;
          end
        end

        S_WAIT: begin
          if (bus.div_out_vld) begin
            r_state         <= S_RESP;
            r_rsp_vld       <= 1'b1;
            r_rsp_quotient  <= bus.div_quotient;
            r_rsp_remainder <= bus.div_remainder;
            r_rsp_dbz       <= 1'b0;
            r_rsp_err       <= 1'b0;
          end else if (r_wait_cnt == WCW'(WDOG - 1)) begin
            // Result considered lost; report an error with zeroed payload.
            r_state         <= S_RESP;
            r_rsp_vld       <= 1'b1;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_dbz       <= 1'b0;
            r_rsp_err       <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (bus.rsp_rdy) begin
            r_state   <= S_IDLE;
            r_rsp_vld <= 1'b0;
            r_rsp_dbz <= 1'b0;
            r_rsp_err <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_rdy       = w_req_rdy;
  assign bus.div_in_vld    = r_div_in_vld;
  assign bus.div_dividend  = r_op_dividend;
  assign bus.div_divisor   = r_op_divisor;
  assign bus.rsp_vld       = r_rsp_vld;
  assign bus.rsp_id        = r_op_id;
  assign bus.rsp_quotient  = r_rsp_quotient;
  assign bus.rsp_remainder = r_rsp_remainder;
  assign bus.rsp_dbz       = r_rsp_dbz;
  assign bus.rsp_err       = r_rsp_err;

endmodule

// File: tb/tb_div_arb.sv
// Purpose : self-checking bench for div_arb with a behavioural divider and round-robin model.
// Latency : n/a.
// Backpressure: bench drives rsp_rdy, including stalled responses.
module tb_div_arb;
  localparam int DW   = 8;
  localparam int NREQ = 4;
  localparam int WDOG = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  int   dm_cnt = 0;
  bit   dm_suppress = 1'b0;

  div_arb_if #(.DW(DW), .NREQ(NREQ)) bus ();

  div_arb #(.DW(DW), .NREQ(NREQ), .WDOG(WDOG)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural divider: after DW+1 consecutive enable cycles it presents
  // the true quotient/remainder for one cycle (unless told to lose it).
  always @(posedge clk) begin
    bus.div_out_vld <= 1'b0;
    if (bus.div_in_vld === 1'b1) begin
      if (dm_cnt == DW) begin
        dm_cnt <= 0;
        if (!dm_suppress) begin
          bus.div_out_vld   <= 1'b1;
          bus.div_quotient  <= (bus.div_divisor == 0) ? 8'hFF : bus.div_dividend / bus.div_divisor;
          bus.div_remainder <= (bus.div_divisor == 0) ? bus.div_dividend : bus.div_dividend % bus.div_divisor;
        end
      end else begin
        dm_cnt <= dm_cnt + 1;
      end
    end else begin
      dm_cnt <= 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
    bus.req_vld[id] = 1'b1;
    bus.req_dividend[id*DW +: DW] = a;
    bus.req_divisor[id*DW +: DW]  = b;
  endtask

  // Issues one request from a single requester and collects what the DUT did.
  task automatic do_job(input int id, input logic [7:0] a, input logic [7:0] b, input bit rdy_now,
                        output int in_cnt, output int lat, output logic [1:0] o_id,
                        output logic [7:0] o_q, output logic [7:0] o_r,
                        output logic o_dbz, output logic o_err, output logic [NREQ-1:0] o_grant);
    int n;
    bus.rsp_rdy = rdy_now;
    bus.req_vld = '0;
    set_req(id, a, b);
    #1;
    o_grant = bus.req_rdy;
    n = 0;
    while (bus.req_rdy[id] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    bus.req_vld = '0;
    in_cnt = 0; lat = -1; o_id = '0; o_q = '0; o_r = '0; o_dbz = 1'b0; o_err = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) tick();
      else #0;
      if (c == 1) begin
        // first observation is cycle T+1; we are already one edge past accept
      end
      if (bus.div_in_vld === 1'b1) in_cnt++;
      if (bus.rsp_vld === 1'b1) begin
        lat = c; o_id = bus.rsp_id; o_q = bus.rsp_quotient; o_r = bus.rsp_remainder;
        o_dbz = bus.rsp_dbz; o_err = bus.rsp_err;
        break;
      end
    end
    if (rdy_now) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_vld = '0; bus.rsp_rdy = 1'b0;
    bus.req_dividend = '0; bus.req_divisor = '0;
    tick(); tick();
    rst = 1'b0;
    if (bus.req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_req_rdy: got %b expected 0000", bus.req_rdy); end checks++;
    if (bus.div_in_vld !== 1'b0) begin errors++; $display("FAIL reset_div_in_vld: got %b expected 0", bus.div_in_vld); end checks++;
    if ({bus.div_dividend, bus.div_divisor} !== 16'h0) begin errors++; $display("FAIL reset_div_ops: got %h expected 0000", {bus.div_dividend, bus.div_divisor}); end checks++;
    if (bus.rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld: got %b expected 0", bus.rsp_vld); end checks++;
    if ({bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_err} !== 20'h0) begin
      errors++; $display("FAIL reset_rsp_fields: got %h expected 0", {bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_err});
    end checks++;
    bus.req_vld = 4'b1111;
    #1;
    if (bus.req_rdy !== 4'b0001) begin errors++; $display("FAIL reset_first_priority: got %b expected 0001", bus.req_rdy); end checks++;
    bus.req_vld = '0;
    #1;
  endtask

  task automatic test_single();
    int ic, lt; logic [1:0] id; logic [7:0] q, r; logic dz, er; logic [NREQ-1:0] g;
    do_job(2, 8'd200, 8'd7, 1'b1, ic, lt, id, q, r, dz, er, g);
    if (g !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", g); end checks++;
    if (ic !== 9) begin errors++; $display("FAIL single_in_vld_cycles: got %0d expected 9", ic); end checks++;
    if (lt !== 11) begin errors++; $display("FAIL single_latency: got %0d expected 11", lt); end checks++;
    if (id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d expected 2", id); end checks++;
    if (q !== 8'd28) begin errors++; $display("FAIL single_quotient: got %0d expected 28", q); end checks++;
    if (r !== 8'd4) begin errors++; $display("FAIL single_remainder: got %0d expected 4", r); end checks++;
    if ({dz, er} !== 2'b00) begin errors++; $display("FAIL single_flags: got %b expected 00", {dz, er}); end checks++;
  endtask

  task automatic test_dbz();
    int ic, lt; logic [1:0] id; logic [7:0] q, r; logic dz, er; logic [NREQ-1:0] g;
    do_job(1, 8'd55, 8'd0, 1'b1, ic, lt, id, q, r, dz, er, g);
    if (ic !== 0) begin errors++; $display("FAIL dbz_in_vld_cycles: got %0d expected 0", ic); end checks++;
    if (lt !== 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", lt); end checks++;
    if (id !== 2'd1) begin errors++; $display("FAIL dbz_id: got %0d expected 1", id); end checks++;
    if (q !== 8'hFF) begin errors++; $display("FAIL dbz_quotient: got %h expected ff", q); end checks++;
    if (r !== 8'd55) begin errors++; $display("FAIL dbz_remainder: got %0d expected 55", r); end checks++;
    if ({dz, er} !== 2'b10) begin errors++; $display("FAIL dbz_flags: got %b expected 10", {dz, er}); end checks++;
    if (bus.rsp_dbz !== 1'b0) begin errors++; $display("FAIL dbz_flag_cleared: got %b expected 0", bus.rsp_dbz); end checks++;
  endtask

  task automatic test_hold();
    int ic, lt; logic [1:0] id; logic [7:0] q, r; logic dz, er; logic [NREQ-1:0] g;
    do_job(3, 8'd100, 8'd9, 1'b0, ic, lt, id, q, r, dz, er, g);
    if (lt !== 11) begin errors++; $display("FAIL hold_latency: got %0d expected 11", lt); end checks++;
    if ({id, q, r} !== {2'd3, 8'd11, 8'd1}) begin errors++; $display("FAIL hold_first_rsp: got %0d/%0d/%0d expected 3/11/1", id, q, r); end checks++;
    set_req(0, 8'd5, 8'd2);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.rsp_vld !== 1'b1) begin errors++; $display("FAIL hold_rsp_vld: got %b expected 1", bus.rsp_vld); end checks++;
      if ({bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder} !== {2'd3, 8'd11, 8'd1}) begin
        errors++; $display("FAIL hold_rsp_stable: got %0d/%0d/%0d expected 3/11/1", bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder);
      end checks++;
      if ({bus.req_rdy, bus.div_in_vld} !== 5'b0) begin errors++; $display("FAIL hold_quiet: got req_rdy=%b in_vld=%b expected 0", bus.req_rdy, bus.div_in_vld); end checks++;
    end
    bus.rsp_rdy = 1'b1;
    #1;
    if (bus.req_rdy !== 4'b0000) begin errors++; $display("FAIL hold_handshake_no_accept: got %b expected 0000", bus.req_rdy); end checks++;
    tick();
    if (bus.rsp_vld !== 1'b0) begin errors++; $display("FAIL hold_rsp_dropped: got %b expected 0", bus.rsp_vld); end checks++;
    if (bus.req_rdy !== 4'b0001) begin errors++; $display("FAIL hold_idle_grant: got %b expected 0001", bus.req_rdy); end checks++;
    bus.req_vld = '0;
    do_job(0, 8'd5, 8'd2, 1'b1, ic, lt, id, q, r, dz, er, g);
    if ({lt, id, q, r} !== {32'd11, 2'd0, 8'd2, 8'd1}) begin errors++; $display("FAIL hold_next_job: got lat=%0d id=%0d q=%0d r=%0d expected 11/0/2/1", lt, id, q, r); end checks++;
  endtask

  task automatic test_watchdog();
    int ic, lt; logic [1:0] id; logic [7:0] q, r; logic dz, er; logic [NREQ-1:0] g;
    dm_suppress = 1'b1;
    do_job(2, 8'd77, 8'd5, 1'b1, ic, lt, id, q, r, dz, er, g);
    dm_suppress = 1'b0;
    if (lt !== DW + 2 + WDOG) begin errors++; $display("FAIL wdog_latency: got %0d expected %0d", lt, DW + 2 + WDOG); end checks++;
    if ({q, r} !== 16'h0) begin errors++; $display("FAIL wdog_payload: got q=%0d r=%0d expected 0/0", q, r); end checks++;
    if ({dz, er} !== 2'b01) begin errors++; $display("FAIL wdog_flags: got %b expected 01", {dz, er}); end checks++;
    do_job(2, 8'd77, 8'd5, 1'b1, ic, lt, id, q, r, dz, er, g);
    if ({lt, q, r, dz, er} !== {32'd11, 8'd15, 8'd2, 2'b00}) begin
      errors++; $display("FAIL wdog_recover: got lat=%0d q=%0d r=%0d dbz=%b err=%b expected 11/15/2/0/0", lt, q, r, dz, er);
    end checks++;
  endtask

  task automatic test_rst_mid_run();
    int ic, lt, bad; logic [1:0] id; logic [7:0] q, r; logic dz, er; logic [NREQ-1:0] g;
    do_job(1, 8'd9, 8'd3, 1'b1, ic, lt, id, q, r, dz, er, g);
    if ({id, q, r} !== {2'd1, 8'd3, 8'd0}) begin errors++; $display("FAIL rst_pre_job: got %0d/%0d/%0d expected 1/3/0", id, q, r); end checks++;
    set_req(1, 8'd90, 8'd4);
    #1;
    tick();
    bus.req_vld = '0;
    tick(); tick(); tick();
    if (bus.div_in_vld !== 1'b1) begin errors++; $display("FAIL rst_run_active: got %b expected 1", bus.div_in_vld); end checks++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if ({bus.div_in_vld, bus.div_dividend, bus.div_divisor, bus.rsp_vld, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_err} !== 38'h0) begin
      errors++; $display("FAIL rst_outputs_zero: got in_vld=%b ops=%h/%h rsp_vld=%b expected all 0", bus.div_in_vld, bus.div_dividend, bus.div_divisor, bus.rsp_vld);
    end checks++;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.rsp_vld !== 1'b0 || bus.div_in_vld !== 1'b0) bad++;
    end
    if (bad !== 0) begin errors++; $display("FAIL rst_no_response: got %0d active cycles expected 0", bad); end checks++;
    set_req(0, 8'd1, 8'd1);
    set_req(2, 8'd1, 8'd1);
    #1;
    if (bus.req_rdy !== 4'b0001) begin errors++; $display("FAIL rst_priority: got %b expected 0001", bus.req_rdy); end checks++;
    bus.req_vld = '0;
    do_job(0, 8'd50, 8'd6, 1'b1, ic, lt, id, q, r, dz, er, g);
    if ({lt, q, r} !== {32'd11, 8'd8, 8'd2}) begin errors++; $display("FAIL rst_next_job: got lat=%0d q=%0d r=%0d expected 11/8/2", lt, q, r); end checks++;
  endtask

  task automatic test_fairness();
    int n, e;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.rsp_rdy = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i * 10 + 20), 8'(i + 3));
    #1;
    for (int j = 0; j < 5; j++) begin
      e = j % NREQ;
      if (bus.req_rdy !== 4'(1 << e)) begin errors++; $display("FAIL fair_grant_%0d: got %b expected %b", j, bus.req_rdy, 4'(1 << e)); end checks++;
      tick();
      if (bus.req_rdy !== 4'b0000) begin errors++; $display("FAIL fair_pulse_%0d: got %b expected 0000", j, bus.req_rdy); end checks++;
      n = 0;
      while (bus.rsp_vld !== 1'b1 && n < 40) begin tick(); n++; end
      if ({bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder} !== {2'(e), 8'((e * 10 + 20) / (e + 3)), 8'((e * 10 + 20) % (e + 3))}) begin
        errors++; $display("FAIL fair_rsp_%0d: got %0d/%0d/%0d expected id %0d", j, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, e);
      end checks++;
      tick();
    end
    bus.req_vld = '0;
    #1;
  endtask

  task automatic test_random();
    bit [NREQ-1:0] pend;
    logic [7:0] av[NREQ];
    logic [7:0] bv[NREQ];
    int last, e, d, bestd, lat, ic, busy_bad, exp_lat, exp_ic;
    bit sup;
    logic [7:0] exp_q, exp_r;
    logic exp_dz, exp_er;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req_vld = '0; bus.rsp_rdy = 1'b0;
    pend = '0;
    last = NREQ - 1;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1 || (pend == '0 && i == NREQ - 1))) begin
          pend[i] = 1'b1;
          av[i] = 8'($urandom);
          bv[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        bus.req_vld[i] = pend[i];
        bus.req_dividend[i*DW +: DW] = av[i];
        bus.req_divisor[i*DW +: DW]  = bv[i];
      end
      #1;
      // Winner: pending requester nearest after the previous winner, cyclically.
      e = -1; bestd = NREQ + 1;
      for (int i = 0; i < NREQ; i++) begin
        d = (i - last - 1 + 2 * NREQ) % NREQ;
        if (pend[i] && d < bestd) begin bestd = d; e = i; end
      end
      if (bus.req_rdy !== 4'(1 << e)) begin errors++; $display("FAIL rand_grant_%0d: got %b expected %b", it, bus.req_rdy, 4'(1 << e)); end checks++;
      sup = (bv[e] != 0) && ($urandom_range(0, 9) == 0);
      dm_suppress = sup;
      tick();
      pend[e] = 1'b0;
      bus.req_vld[e] = 1'b0;
      lat = -1; ic = 0; busy_bad = 0;
      for (int c = 1; c <= 40; c++) begin
        if (c > 1) tick();
        if (bus.div_in_vld === 1'b1) ic++;
        if (bus.req_rdy !== 4'b0000) busy_bad++;
        if (bus.rsp_vld === 1'b1) begin lat = c; break; end
      end
      dm_suppress = 1'b0;
      if (bv[e] == 0) begin
        exp_lat = 1; exp_ic = 0; exp_q = 8'hFF; exp_r = av[e]; exp_dz = 1'b1; exp_er = 1'b0;
      end else if (sup) begin
        exp_lat = DW + 2 + WDOG; exp_ic = DW + 1; exp_q = 8'h00; exp_r = 8'h00; exp_dz = 1'b0; exp_er = 1'b1;
      end else begin
        exp_lat = DW + 3; exp_ic = DW + 1; exp_q = av[e] / bv[e]; exp_r = av[e] % bv[e]; exp_dz = 1'b0; exp_er = 1'b0;
      end
      if (lat !== exp_lat) begin errors++; $display("FAIL rand_latency_%0d: got %0d expected %0d", it, lat, exp_lat); end checks++;
      if (ic !== exp_ic) begin errors++; $display("FAIL rand_in_vld_%0d: got %0d expected %0d", it, ic, exp_ic); end checks++;
      if (busy_bad !== 0) begin errors++; $display("FAIL rand_busy_rdy_%0d: got %0d cycles with req_rdy expected 0", it, busy_bad); end checks++;
      if (bus.rsp_id !== 2'(e)) begin errors++; $display("FAIL rand_id_%0d: got %0d expected %0d", it, bus.rsp_id, e); end checks++;
      if ({bus.rsp_quotient, bus.rsp_remainder} !== {exp_q, exp_r}) begin
        errors++; $display("FAIL rand_result_%0d: got q=%0d r=%0d expected q=%0d r=%0d (%0d/%0d)", it, bus.rsp_quotient, bus.rsp_remainder, exp_q, exp_r, av[e], bv[e]);
      end checks++;
      if ({bus.rsp_dbz, bus.rsp_err} !== {exp_dz, exp_er}) begin errors++; $display("FAIL rand_flags_%0d: got %b expected %b", it, {bus.rsp_dbz, bus.rsp_err}, {exp_dz, exp_er}); end checks++;
      repeat ($urandom_range(0, 3)) tick();
      bus.rsp_rdy = 1'b1;
      tick();
      bus.rsp_rdy = 1'b0;
      if (bus.rsp_vld !== 1'b0) begin errors++; $display("FAIL rand_rsp_release_%0d: got %b expected 0", it, bus.rsp_vld); end checks++;
      last = e;
    end
    bus.req_vld = '0;
  endtask

  initial begin
    bus.req_vld = '0;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    bus.rsp_rdy = 1'b0;
    test_reset();
    test_single();
    test_dbz();
    test_hold();
    test_watchdog();
    test_rst_mid_run();
    test_fairness();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_arb.md
Name: div_arb

Overview:
- Round-robin request scheduler that shares one sequential radix-2 divider (DW-bit, DW+1 iteration cycles) among NREQ requesters.
- Accepts one divide request at a time and sequences the divider's in_vld/operand interface for exactly the required iteration count.
- Captures the divider result and returns it with the requester ID through a valid/ready response port.
- Handles divide-by-zero locally and guards against a missing divider result with a watchdog.

Parameters:
- DW, 8: operand, quotient and remainder width; must match the attached divider.
- NREQ, 4: number of requesters, 2..16.
- IDW (localparam), $clog2(NREQ): requester ID width.
- WDOG, 3: maximum cycles spent in WAIT before the result is declared lost.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_vld  in  NREQ  per-requester request valid.
- req_rdy  out  NREQ  one-hot accept; operands are taken in the cycle where req_vld[i]&req_rdy[i].
- req_dividend  in  NREQ*DW  requester i occupies slice [i*DW +: DW].
- req_divisor  in  NREQ*DW  same packing as req_dividend.
- div_in_vld  out  1  divider iteration enable.
- div_dividend  out  DW  operand to divider.
- div_divisor  out  DW  operand to divider.
- div_out_vld  in  1  divider result strobe, one cycle.
- div_quotient  in  DW  divider quotient.
- div_remainder  in  DW  divider remainder.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response accept.
- rsp_id  out  IDW  index of the requester that issued the request.
- rsp_quotient  out  DW  quotient.
- rsp_remainder  out  DW  remainder.
- rsp_dbz  out  1  divisor was zero.
- rsp_err  out  1  watchdog expired; quotient and remainder are invalid.

Behaviour:
- Divider contract:
  - div_in_vld is held high with stable operands for exactly DW+1 consecutive cycles.
  - div_out_vld is expected in the cycle after the last div_in_vld cycle.
  - div_in_vld is low in every other cycle.
- Reset (rst high at an edge):
  - state=IDLE; all outputs 0; run_cnt=0.
  - RR pointer set so requester 0 has top priority on the first arbitration.
  - Reset mid-operation abandons the job silently; no response is issued.
- FSM states IDLE, RUN, WAIT, RESP; state and all outputs are registered except req_rdy.
- IDLE:
  - req_rdy is combinational: one-hot on the first req_vld bit at or after (last_grant+1) mod NREQ, and 0 if no request is pending.
  - On accept: latch dividend, divisor and ID into op regs; last_grant<=granted index.
  - If divisor==0, go to RESP with quotient={DW{1'b1}}, remainder=dividend, rsp_dbz=1.
  - Otherwise go to RUN with run_cnt<=0.
- RUN:
  - div_in_vld=1; div_dividend/div_divisor are driven from op regs, which stay constant for the whole job.
  - run_cnt increments each cycle; when run_cnt==DW, go to WAIT.
  - RUN lasts exactly DW+1 cycles.
- WAIT:
  - div_in_vld=0.
  - On div_out_vld, capture quotient and remainder, then go to RESP.
  - A wait counter runs; if WDOG cycles pass without div_out_vld, go to RESP with rsp_err=1 and quotient/remainder=0.
- RESP:
  - rsp_vld=1; rsp_* fields stay stable until rsp_rdy.
  - On rsp_vld&rsp_rdy, go to IDLE and clear rsp_dbz/rsp_err.
  - No new request is accepted in the handshake cycle.
- req_rdy is 0 in all states except IDLE.
- div_out_vld outside WAIT is ignored.
- Latency, with accept at cycle T:
  - div_in_vld high T+1..T+DW+1.
  - div_out_vld expected at T+DW+2.
  - rsp_vld first high at T+DW+3.
  - Divide-by-zero: rsp_vld at T+1.
- Fairness: a continuously asserting requester is served within NREQ jobs.
- Requesters hold req_vld and operands until accepted; a dropped req_vld before accept is simply not granted.

Test Plan:
- DW=8, NREQ=4; single req on ID2, 200/7, rsp_rdy=1 -> div_in_vld exactly 9 cycles; rsp_vld at T+11 with id=2, q=28, r=4, dbz=0, err=0.
- req_vld=4'b1111 held continuously -> grant order 0,1,2,3,0; each req_rdy is a one-cycle one-hot pulse.
- ID1: 55/0 -> no div_in_vld activity; rsp at T+1 with q=8'hFF, r=55, dbz=1.
- rsp_rdy held low for 5 cycles after rsp_vld -> rsp fields stable; req_rdy=0 and no new div_in_vld until the handshake.
- Divider model suppresses div_out_vld -> after 3 WAIT cycles rsp_err=1, q=0, r=0; next request then completes normally.
- rst pulsed during RUN cycle 4 -> next cycle all outputs 0 and no response; requester 0 wins the next arbitration.
